// File: rtl/microwave_timer_dp_if.sv
// Signal bundle between the microwave control unit (master) and the timer datapath (slave).
// sel/run/toggle are levels held by the control unit; btn_up/btn_down are one-cycle pulses;
// all outputs are registered levels, and there is no valid/ready back-pressure on this link.
interface microwave_timer_dp_if;
  logic [1:0] sel;
  logic       run;
  logic       toggle;
  logic       btn_up;
  logic       btn_down;
  logic [6:0] min_val;
  logic [5:0] sec_val;
  logic       finish;
  logic       blink;
  logic       buzzer;

  modport master (
    output sel, run, toggle, btn_up, btn_down,
    input  min_val, sec_val, finish, blink, buzzer
  );

  modport slave (
    input  sel, run, toggle, btn_up, btn_down,
    output min_val, sec_val, finish, blink, buzzer
  );
endinterface

// File: rtl/microwave_timer_dp.sv
// Microwave timer datapath: mm:ss edit, 1 Hz countdown, finish flag, alert blink and buzzer.
// Optional buzzer tone generator enabled by defining MICROWAVE_BUZZER_EN.
module microwave_timer_dp #(
    parameter int SEC_DIV   = 100_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int BUZZ_HALF = 25_000,
    parameter int MAX_MIN   = 99
) (
    input logic                clk,
    input logic                rst,
    microwave_timer_dp_if.slave bus
);

    if (SEC_DIV < 2 || BLINK_DIV < 2 || BUZZ_HALF < 2 || MAX_MIN < 1 || MAX_MIN > 127) begin : g_param_check
        $error("microwave_timer_dp: parameter out of range");
    end

    localparam int SEC_W   = $clog2(SEC_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0]         MIN_TOP    = 7'(MAX_MIN);

    logic [SEC_W-1:0]   sec_cnt, sec_cnt_d;
    logic               tick;
    logic [6:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               finish_q;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               toggle_q;
    logic               edit_en, up_only, dn_only;

    assign edit_en = !bus.run && !bus.toggle;
    assign up_only = bus.btn_up && !bus.btn_down;
    assign dn_only = bus.btn_down && !bus.btn_up;
    assign tick    = bus.run && (sec_cnt == SEC_LAST);

    always_comb begin
        sec_cnt_d = '0;
        if (bus.run && !tick) sec_cnt_d = sec_cnt + 1'b1;
    end

    // A tick only happens while running, so it never competes with an edit.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (tick) begin
            if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
            end else if (min_q != 7'd0) begin
                min_d = min_q - 7'd1;
                sec_d = 6'd59;
            end
        end else if (edit_en) begin
            case (bus.sel)
                2'b01: begin
                    if (up_only)      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    else if (dn_only) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                end
                2'b10: begin
                    if (up_only)      min_d = (min_q == MIN_TOP) ? 7'd0 : min_q + 7'd1;
                    else if (dn_only) min_d = (min_q == 7'd0) ? MIN_TOP : min_q - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // toggle_q marks that the previous cycle was already in alert, so entry restarts high.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (bus.toggle) begin
            if (!toggle_q) begin
                blink_d = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_d = !blink_q;
            end else begin
                blink_cnt_d = blink_cnt + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            finish_q  <= 1'b0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sec_cnt   <= sec_cnt_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            finish_q  <= bus.run && (min_q == 7'd0) && (sec_q == 6'd0);
            blink_cnt <= blink_cnt_d;
            blink_q   <= blink_d;
            toggle_q  <= bus.toggle;
        end
    end

    assign bus.min_val = min_q;
    assign bus.sec_val = sec_q;
    assign bus.finish  = finish_q;
    assign bus.blink   = blink_q;

`ifdef MICROWAVE_BUZZER_EN
    localparam int BUZZ_W = $clog2(BUZZ_HALF);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_HALF - 1);

    logic [BUZZ_W-1:0] buzz_cnt;
    logic              buzz_q;

    // Gated by the next blink value so the tone lines up with the visible blink-high phase.
    always_ff @(posedge clk) begin
        if (rst || !blink_d) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!blink_q) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b1;
        end else if (buzz_cnt == BUZZ_LAST) begin
            buzz_cnt <= '0;
            buzz_q   <= !buzz_q;
        end else begin
            buzz_cnt <= buzz_cnt + 1'b1;
        end
    end

    assign bus.buzzer = buzz_q;
`else
    assign bus.buzzer = 1'b0;
`endif

endmodule

// File: doc/microwave_timer_dp.md
Name: microwave_timer_dp

Overview:
- Timer datapath directly downstream of the microwave control unit.
- Consumes the mode strobes `sel`, `run` and `toggle`, plus up/down button pulses.
- Holds the programmed minutes:seconds value, counts it down at 1 Hz while running, and returns `finish` to the control unit.
- Drives the blink and buzzer indications shown while the control unit is in its finish state.

Parameters:
- SEC_DIV, 100_000_000: clk cycles per countdown second.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period.
- BUZZ_HALF, 25_000: clk cycles per buzzer half-period (2 kHz at 100 MHz).
- MAX_MIN, 99: highest programmable minute value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sel  in  2  edit select from control unit; [0]=seconds edit, [1]=minutes edit.
- run  in  1  countdown enable from control unit.
- toggle  in  1  finish/alert state from control unit.
- btn_up  in  1  single-cycle increment pulse, debounced and edge-detected upstream.
- btn_down  in  1  single-cycle decrement pulse, same conditioning.
- min_val  out  7  current minutes, 0..MAX_MIN.
- sec_val  out  6  current seconds, 0..59.
- finish  out  1  time-expired indication to control unit.
- blink  out  1  alert blink for LED/FND.
- buzzer  out  1  buzzer square wave.

Behaviour:
- Reset: one clock, synchronous active-high reset as decided. On a `rst`-high edge, all registers clear: min_val=0, sec_val=0, finish=0, blink=0, buzzer=0, and all divider counters=0. This holds mid-countdown and mid-alert.
- Edit (run=0, toggle=0):
  - sel==2'b01: btn_up does sec+1 with 59 wrapping to 0 (no carry into minutes). btn_down does sec-1 with 0 wrapping to 59.
  - sel==2'b10: btn_up does min+1 with MAX_MIN wrapping to 0. btn_down does min-1 with 0 wrapping to MAX_MIN.
  - Update visible the cycle after the pulse.
  - btn_up and btn_down together: no change.
  - sel==2'b00 or 2'b11: buttons ignored.
  - Buttons ignored whenever run or toggle is high.
- Tick divider:
  - Counts only while run=1; forced to 0 whenever run=0.
  - tick is asserted when the count equals SEC_DIV-1, then the count returns to 0.
  - First decrement lands exactly SEC_DIV cycles after run rises.
- Decrement on tick:
  - sec>0: sec-1.
  - sec==0, min>0: min-1, sec=59.
  - 0:00: hold.
- Value is retained when run drops: a cancel through the control unit's run/cancel button leaves the remaining time, and the value persists through idle.
- finish:
  - Registered; finish <= run & (min_val==0) & (sec_val==0).
  - Rises one cycle after the value reaches 0:00 while running, or one cycle after run rises with 0:00 already loaded.
  - Stays high while both conditions hold; clears the cycle after run falls.
- blink:
  - While toggle=1: a counter runs, and blink starts at 1 on the first toggle cycle and inverts every BLINK_DIV cycles.
  - toggle=0: blink=0 and the counter is cleared, so each re-entry starts at 1.
- Divider widths: $clog2 of each divisor; no overflow beyond the terminal count.

Optional Feature:
- Macro: MICROWAVE_BUZZER_EN.
- Defined:
  - A BUZZ_HALF counter runs only while toggle=1 and blink=1.
  - buzzer starts at 1 and inverts every BUZZ_HALF cycles.
  - buzzer is forced to 0 and the counter cleared whenever toggle=0 or blink=0.
- Undefined:
  - No buzzer counter is synthesized.
  - buzzer is constant 0.
  - Port list is unchanged.

Test Plan (SEC_DIV=10, BLINK_DIV=4, BUZZ_HALF=2, MAX_MIN=99):
1. Seconds edit wrap: rst, sel=01, 1 btn_down pulse -> sec_val=59, min_val=0; then 2 btn_up pulses -> sec_val=1.
2. Minutes edit wrap and button priority:
   - sel=10, btn_down -> min_val=99; btn_up -> min_val=0.
   - btn_up+btn_down same cycle -> unchanged.
   - sel=00 with btn_up -> unchanged.
3. Borrow: load 1:00, run=1 -> 10 cycles later 0:59, 20 cycles later 0:58. btn_up during run -> ignored.
4. Finish handshake:
   - Load 0:02, run=1 -> 0:00 at cycle 20, finish=1 at cycle 21, held.
   - run=0 -> finish=0 next cycle.
   - Load 0:00 with run=1 -> finish=1 on the second cycle.
5. Alert: toggle=1 -> blink 1,1,1,1,0,0,0,0,1... With MICROWAVE_BUZZER_EN, buzzer 1,1,0,0 during blink-high and 0 during blink-low. Without the macro, buzzer stays 0.
6. Reset mid-operation: rst during countdown at 0:37 -> next edge min_val=0, sec_val=0, finish=0. rst during toggle -> blink=0 and buzzer=0 next edge.
